// File: rtl/mul_result_wb_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// mul_result_wb_if : product-input and register-file writeback handshakes
// Rev 1.0
// ---------------------------------------------------------------------------
interface mul_result_wb_if #(
   parameter int DATA_W = 64,
   parameter int ADDR_W = 5
);
   logic                  in_valid;
   logic                  in_ready;
   logic [2*DATA_W-1:0]   in_prod;
   logic                  in_ovf;
   logic [ADDR_W-1:0]     in_rd_lo;
   logic [ADDR_W-1:0]     in_rd_hi;
   logic                  in_want_hi;
   logic                  wb_valid;
   logic                  wb_ready;
   logic [ADDR_W-1:0]     wb_addr;
   logic [DATA_W-1:0]     wb_data;

   modport master (
      output in_valid, in_prod, in_ovf, in_rd_lo, in_rd_hi, in_want_hi,
      input  in_ready,
      input  wb_valid, wb_addr, wb_data,
      output wb_ready
   );

   modport slave (
      input  in_valid, in_prod, in_ovf, in_rd_lo, in_rd_hi, in_want_hi,
      output in_ready,
      output wb_valid, wb_addr, wb_data,
      input  wb_ready
   );
endinterface
`default_nettype wire

// File: rtl/mul_result_wb.sv
`default_nettype none
// ---------------------------------------------------------------------------
// mul_result_wb : captures a 2*DATA_W product and writes it back LO then HI
// Rev 1.0
// ---------------------------------------------------------------------------
module mul_result_wb #(
   parameter int DATA_W = 64,
   parameter int ADDR_W = 5,
   parameter int HI_EN  = 1
) (
   input  wire logic          clk,
   input  wire logic          rst_n,
   mul_result_wb_if.slave     bus,
   output logic               ovf_sticky,
   input  wire logic          ovf_clr,
   output logic               busy
);

   localparam logic c_HI_EN = (HI_EN != 0);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_WB_LO = 2'd1,
      ST_WB_HI = 2'd2
   } state_t;

   state_t                r_state;
   state_t                w_state_nxt;
   logic [2*DATA_W-1:0]   r_prod;
   logic [ADDR_W-1:0]     r_rd_lo;
   logic [ADDR_W-1:0]     r_rd_hi;
   logic                  r_want_hi;
   logic                  r_ovf_sticky;
   logic                  w_last;
   logic                  w_in_ready;
   logic                  w_accept;

   // The final beat may retire and a new product load in the same cycle.
   always_comb begin
      w_last     = ((r_state == ST_WB_LO) && !r_want_hi) || (r_state == ST_WB_HI);
      w_in_ready = (r_state == ST_IDLE) || (bus.wb_ready && w_last);
      w_accept   = bus.in_valid && w_in_ready;
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_IDLE: begin
            if (w_accept) w_state_nxt = ST_WB_LO;
         end
         ST_WB_LO: begin
            if (bus.wb_ready) begin
               if (r_want_hi)     w_state_nxt = ST_WB_HI;
               else if (w_accept) w_state_nxt = ST_WB_LO;
               else               w_state_nxt = ST_IDLE;
            end
         end
         ST_WB_HI: begin
            if (bus.wb_ready) begin
               if (w_accept) w_state_nxt = ST_WB_LO;
               else          w_state_nxt = ST_IDLE;
            end
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_prod    <= '0;
         r_rd_lo   <= '0;
         r_rd_hi   <= '0;
         r_want_hi <= 1'b0;
      end else if (w_accept) begin
         r_prod    <= bus.in_prod;
         r_rd_lo   <= bus.in_rd_lo;
         r_rd_hi   <= bus.in_rd_hi;
         r_want_hi <= bus.in_want_hi & c_HI_EN;
      end
   end

   // Set has priority over clear so an overflow is never lost.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_ovf_sticky <= 1'b0;
      end else if (w_accept && bus.in_ovf) begin
         r_ovf_sticky <= 1'b1;
      end else if (ovf_clr) begin
         r_ovf_sticky <= 1'b0;
      end
   end

   always_comb begin
      bus.wb_valid = 1'b0;
      bus.wb_addr  = '0;
      bus.wb_data  = '0;
      case (r_state)
         ST_WB_LO: begin
            bus.wb_valid = 1'b1;
            bus.wb_addr  = r_rd_lo;
            bus.wb_data  = r_prod[DATA_W-1:0];
         end
         ST_WB_HI: begin
            bus.wb_valid = 1'b1;
            bus.wb_addr  = r_rd_hi;
            bus.wb_data  = r_prod[2*DATA_W-1:DATA_W];
         end
         default: begin
            bus.wb_valid = 1'b0;
         end
      endcase
   end

   assign bus.in_ready = w_in_ready;
   assign ovf_sticky   = r_ovf_sticky;
   assign busy         = (r_state != ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_mul_result_wb.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_mul_result_wb : scoreboard bench for the multiplier writeback stage
// Rev 1.0
// ---------------------------------------------------------------------------
module tb_mul_result_wb;

   localparam int DATA_W = 64;
   localparam int ADDR_W = 5;
   localparam int HI_EN  = 1;

   typedef struct packed {
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] data;
   } beat_t;

   logic clk;
   logic rst_n;
   logic ovf_clr;
   logic ovf_sticky;
   logic busy;

   mul_result_wb_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

   mul_result_wb #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .HI_EN(HI_EN)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .bus        (bus),
      .ovf_sticky (ovf_sticky),
      .ovf_clr    (ovf_clr),
      .busy       (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int    errors = 0;
   int    checks = 0;
   beat_t q[$];
   int    pushed_now = 0;
   logic  sticky_model = 1'b0;
   logic  next_sticky = 1'b0;
   logic  prev_stall = 1'b0;
   beat_t prev_beat;

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic logic [127:0] smul(input logic [63:0] a, input logic [63:0] b);
      logic signed [127:0] sa;
      logic signed [127:0] sb;
      sa = {{64{a[63]}}, a};
      sb = {{64{b[63]}}, b};
      return sa * sb;
   endfunction

   // One clock of stimulus; the model records the beats every accepted product owes.
   task automatic drive(input logic v, input logic [127:0] p, input logic ovf,
                        input logic [ADDR_W-1:0] lo, input logic [ADDR_W-1:0] hi,
                        input logic want, input logic wbr, input logic clr);
      logic acc;
      @(negedge clk);
      sticky_model   = next_sticky;
      pushed_now     = 0;
      bus.in_valid   = v;
      bus.in_prod    = p;
      bus.in_ovf     = ovf;
      bus.in_rd_lo   = lo;
      bus.in_rd_hi   = hi;
      bus.in_want_hi = want;
      bus.wb_ready   = wbr;
      ovf_clr        = clr;
      #1;
      chk("in_ready", bus.in_ready, (q.size() == 0) || (wbr && q.size() == 1));
      chk("ovf_sticky", ovf_sticky, sticky_model);
      acc = v && bus.in_ready;
      if (acc) begin
         q.push_back('{addr: lo, data: p[63:0]});
         pushed_now = 1;
         if (want && HI_EN != 0) begin
            q.push_back('{addr: hi, data: p[127:64]});
            pushed_now = 2;
         end
      end
      next_sticky = (acc && ovf) ? 1'b1 : (clr ? 1'b0 : sticky_model);
   endtask

   task automatic idle(input logic wbr);
      drive(1'b0, '0, 1'b0, '0, '0, 1'b0, wbr, 1'b0);
   endtask

   task automatic reset_now();
      @(negedge clk);
      pushed_now   = 0;
      bus.in_valid = 1'b0;
      rst_n        = 1'b0;
      #1;
      chk("rst_wb_valid", bus.wb_valid, 1'b0);
      chk("rst_busy", busy, 1'b0);
      chk("rst_in_ready", bus.in_ready, 1'b1);
      chk("rst_sticky", ovf_sticky, 1'b0);
      q.delete();
      sticky_model = 1'b0;
      next_sticky  = 1'b0;
      prev_stall   = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   // Monitor: compares every presented beat against the head of the scoreboard.
   initial begin
      beat_t b;
      int    outstanding;
      forever begin
         @(negedge clk);
         #2;
         outstanding = q.size() - pushed_now;
         chk("wb_valid", bus.wb_valid, outstanding > 0);
         chk("busy", busy, outstanding > 0);
         if (prev_stall) begin
            chk("stall_hold_addr", bus.wb_addr, prev_beat.addr);
            chk("stall_hold_data", bus.wb_data, prev_beat.data);
         end
         if (bus.wb_valid && bus.wb_ready) begin
            if (outstanding <= 0) begin
               chk("unexpected_beat", bus.wb_valid, 1'b0);
            end else begin
               b = q.pop_front();
               chk("wb_addr", bus.wb_addr, b.addr);
               chk("wb_data", bus.wb_data, b.data);
            end
         end
         prev_stall     = bus.wb_valid && !bus.wb_ready;
         prev_beat.addr = bus.wb_addr;
         prev_beat.data = bus.wb_data;
      end
   end

   initial begin
      logic [127:0] p;
      rst_n          = 1'b0;
      bus.in_valid   = 1'b0;
      bus.in_prod    = '0;
      bus.in_ovf     = 1'b0;
      bus.in_rd_lo   = '0;
      bus.in_rd_hi   = '0;
      bus.in_want_hi = 1'b0;
      bus.wb_ready   = 1'b0;
      ovf_clr        = 1'b0;
      repeat (3) @(negedge clk);
      #1;
      chk("reset_wb_valid", bus.wb_valid, 1'b0);
      chk("reset_wb_addr", bus.wb_addr, '0);
      chk("reset_wb_data", bus.wb_data, '0);
      chk("reset_busy", busy, 1'b0);
      chk("reset_sticky", ovf_sticky, 1'b0);
      chk("reset_in_ready", bus.in_ready, 1'b1);
      @(negedge clk);
      rst_n = 1'b1;

      // Single LO beat, then a signed product needing both halves.
      drive(1'b1, smul(64'd345, 64'd922), 1'b0, 5'd3, 5'd9, 1'b0, 1'b1, 1'b0);
      idle(1'b1);
      idle(1'b1);
      drive(1'b1, smul(-64'sd345, 64'sd22), 1'b0, 5'd4, 5'd5, 1'b1, 1'b1, 1'b0);
      idle(1'b1);
      idle(1'b1);
      idle(1'b1);

      // Stall in WB_LO while a second product waits, then the HI-beat bypass.
      drive(1'b1, smul(64'd1000, -64'sd7), 1'b0, 5'd6, 5'd7, 1'b1, 1'b0, 1'b0);
      p = smul(64'h1234_5678_9abc_def0, 64'h0fed_cba9_8765_4321);
      repeat (3) drive(1'b1, p, 1'b0, 5'd8, 5'd10, 1'b0, 1'b0, 1'b0);
      drive(1'b1, p, 1'b0, 5'd8, 5'd10, 1'b0, 1'b1, 1'b0);
      drive(1'b1, p, 1'b0, 5'd8, 5'd10, 1'b0, 1'b1, 1'b0);
      idle(1'b1);
      idle(1'b1);

      // Back-to-back LO-only products at full rate.
      for (int i = 0; i < 12; i++) begin
         drive(1'b1, {$urandom(), $urandom(), $urandom(), $urandom()}, 1'b0,
               5'(i + 1), 5'd0, 1'b0, 1'b1, 1'b0);
      end
      idle(1'b1);
      idle(1'b1);

      // Sticky overflow: set, clear-with-set, clear alone.
      drive(1'b1, smul(64'd5, 64'd6), 1'b1, 5'd11, 5'd12, 1'b0, 1'b1, 1'b0);
      drive(1'b1, smul(64'd7, 64'd8), 1'b1, 5'd13, 5'd14, 1'b0, 1'b1, 1'b1);
      drive(1'b0, '0, 1'b0, '0, '0, 1'b0, 1'b1, 1'b1);
      idle(1'b1);
      idle(1'b1);

      // Reset while the HI beat is presented: nothing may follow.
      drive(1'b1, smul(-64'sd99, 64'd3), 1'b1, 5'd15, 5'd16, 1'b1, 1'b1, 1'b0);
      idle(1'b1);
      reset_now();
      repeat (4) idle(1'b1);

      // Randomised traffic with random backpressure.
      for (int i = 0; i < 600; i++) begin
         p = smul({$urandom(), $urandom()}, ($urandom_range(0, 3) == 0) ?
                  64'($urandom_range(0, 1000)) : {$urandom(), $urandom()});
         drive($urandom_range(0, 9) < 7, p, $urandom_range(0, 9) == 0,
               5'($urandom()), 5'($urandom()), 1'($urandom()),
               $urandom_range(0, 9) < 7, $urandom_range(0, 9) == 0);
      end
      repeat (4) idle(1'b1);
      chk("drained", 32'(q.size()), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
`default_nettype wire
